cpu_run_controller: RTL and testbench

Hardware run controller for the single-cycle R-format CPU: streams a program image into instruction memory, drives the CPU's fetch address from its own PC register until the program end, then streams the register-file contents out on a valid/ready port. Sits between the host/load interface and the CPU core; replaces software stimulus so the core can run standalone on silicon/FPGA.

---
 rtl/cpu_ctrl_pkg.sv | 16 +
 rtl/rf_dump_streamer.sv | 34 +++
 rtl/cpu_run_controller.sv | 121 ++++++++++++
 tb/tb_cpu_run_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU run controller.
package cpu_ctrl_pkg;
    localparam int WORD_W         = 32;
    localparam int RF_AW          = 5;
    localparam int DEF_INSTR_MAX  = 128;
    localparam int DEF_REG_MAX    = 32;
    localparam int DEF_MAX_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;
endpackage

// File: rtl/rf_dump_streamer.sv
// Walks the register file R0..R[REG_MAX-1] onto a valid/ready stream.
module rf_dump_streamer
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_MAX = DEF_REG_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              dump_ready,
    input  logic [WORD_W-1:0] rf_rdata,
    output logic [RF_AW-1:0]  rf_raddr,
    output logic              dump_valid,
    output logic [WORD_W-1:0] dump_data,
    output logic              dump_last,
    output logic              last_xfer
);
    logic [RF_AW-1:0] idx;

    // Index parks at 0 outside DUMP so every dump starts from R0.
    always_ff @(posedge clk) begin
        if (rst || !active)
            idx <= '0;
        else if (dump_valid && dump_ready)
            idx <= idx + 1'b1;
    end

    // The RF is frozen (cpu_en low) during DUMP, so data stays stable under stall.
    assign rf_raddr   = idx;
    assign dump_valid = active;
    assign dump_data  = active ? rf_rdata : '0;
    assign dump_last  = active && (idx == RF_AW'(REG_MAX - 1));
    assign last_xfer  = dump_valid && dump_ready && dump_last;
endmodule

// File: rtl/cpu_run_controller.sv
// Load program image, run the CPU from its own PC until program end, then dump registers.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_MAX  = DEF_INSTR_MAX,
    parameter int REG_MAX    = DEF_REG_MAX,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    localparam int IAW       = $clog2(INSTR_MAX),
    localparam int CW        = $clog2(MAX_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    output logic              im_we,
    output logic [IAW-1:0]    im_addr,
    output logic [7:0]        im_wdata,
    output logic [WORD_W-1:0] pc_out,
    input  logic [WORD_W-1:0] pc_next,
    output logic              cpu_en,
    output logic [RF_AW-1:0]  rf_raddr,
    input  logic [WORD_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [WORD_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              misalign
);
    state_t         state, state_nx;
    logic [IAW-1:0] byte_cnt;
    logic [CW-1:0]  cyc_cnt;
    logic           last_xfer;
    logic           bad_pc, wd_hit, pc_end, run_exit, load_end;

    assign bad_pc   = pc_next[1:0] != 2'b00;
    assign wd_hit   = cyc_cnt == CW'(MAX_CYCLES - 1);
    // Unsigned compare also catches jumps past the end of the image.
    assign pc_end   = pc_out >= WORD_W'(INSTR_MAX - 4);
    assign run_exit = bad_pc || wd_hit || pc_end;
    assign load_end = ld_valid && (byte_cnt == IAW'(INSTR_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: if (start)     state_nx = ST_LOAD;
            ST_LOAD:          if (load_end)  state_nx = ST_RUN;
            ST_RUN:           if (run_exit)  state_nx = ST_DUMP;
            ST_DUMP:          if (last_xfer) state_nx = ST_DONE;
            default:                         state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            pc_out   <= '0;
            cyc_cnt  <= '0;
            timeout  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        byte_cnt <= '0;
                        pc_out   <= '0;
                        cyc_cnt  <= '0;
                        timeout  <= 1'b0;
                        misalign <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) byte_cnt <= byte_cnt + 1'b1;
                    if (load_end) pc_out <= '0;
                end
                ST_RUN: begin
                    // The instruction at pc_out executes this edge regardless of exit cause.
                    cyc_cnt <= cyc_cnt + 1'b1;
                    if (bad_pc)    misalign <= 1'b1;
                    if (wd_hit)    timeout  <= 1'b1;
                    if (!run_exit) pc_out   <= pc_next;
                end
                default: ;
            endcase
        end
    end

    assign ld_ready = state == ST_LOAD;
    assign im_we    = ld_ready && ld_valid;
    assign im_addr  = byte_cnt;
    assign im_wdata = ld_ready ? ld_data : 8'h00;
    assign cpu_en   = state == ST_RUN;
    assign busy     = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_DUMP);
    assign done     = state == ST_DONE;

    rf_dump_streamer #(
        .REG_MAX (REG_MAX)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .active     (state == ST_DUMP),
        .dump_ready (dump_ready),
        .rf_rdata   (rf_rdata),
        .rf_raddr   (rf_raddr),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .last_xfer  (last_xfer)
    );
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench: main controller plus a short-watchdog instance for the timeout path.
module tb_cpu_run_controller;
    localparam int IM = 128;
    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst, start, start_b, ld_valid, dump_ready;
    logic [7:0]  ld_data;
    int          pc_mode;
    int          errors = 0;
    int          checks = 0;

    logic        ld_ready, im_we, cpu_en, dump_valid, dump_last, busy, done, timeout, misalign;
    logic [6:0]  im_addr;
    logic [7:0]  im_wdata;
    logic [31:0] pc_out, pc_next, rf_rdata, dump_data;
    logic [4:0]  rf_raddr;

    logic        ld_ready_b, im_we_b, cpu_en_b, dump_valid_b, dump_last_b, busy_b, done_b, timeout_b, misalign_b;
    logic [6:0]  im_addr_b;
    logic [7:0]  im_wdata_b;
    logic [31:0] pc_out_b, pc_next_b, rf_rdata_b, dump_data_b;
    logic [4:0]  rf_raddr_b;

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_val(input logic [4:0] i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] model_pc(input logic [31:0] pc, input int mode);
        case (mode)
            1:       return 32'd8;
            2:       return (pc == 32'd4) ? 32'd6 : pc + 32'd4;
            default: return pc + 32'd4;
        endcase
    endfunction

    always_comb begin
        pc_next   = model_pc(pc_out, pc_mode);
        pc_next_b = model_pc(pc_out_b, pc_mode);
    end
    assign rf_rdata   = rf_val(rf_raddr);
    assign rf_rdata_b = rf_val(rf_raddr_b);

    cpu_run_controller dut (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .pc_out(pc_out), .pc_next(pc_next), .cpu_en(cpu_en), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last), .busy(busy), .done(done),
        .timeout(timeout), .misalign(misalign)
    );

    cpu_run_controller #(.MAX_CYCLES(16)) dut_wd (
        .clk(clk), .rst(rst), .start(start_b), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
        .ld_data(ld_data), .im_we(im_we_b), .im_addr(im_addr_b), .im_wdata(im_wdata_b),
        .pc_out(pc_out_b), .pc_next(pc_next_b), .cpu_en(cpu_en_b), .rf_raddr(rf_raddr_b),
        .rf_rdata(rf_rdata_b), .dump_valid(dump_valid_b), .dump_ready(dump_ready),
        .dump_data(dump_data_b), .dump_last(dump_last_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b), .misalign(misalign_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1;
        else   start   = 1'b1;
        step();
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic load_a();
        int k  = 0;
        int nb = 0;
        pulse_start(1'b0);
        chk("ld_ready_on", ld_ready, 1);
        while (nb < IM && k < 600) begin
            ld_valid = (k % 2 == 0);
            ld_data  = 8'(nb) ^ 8'h5A;
            #1;
            chk("im_we", im_we, ld_valid);
            if (im_we) begin
                chk("im_addr", im_addr, nb);
                chk("im_wdata", im_wdata, 8'(nb) ^ 8'h5A);
                nb++;
            end
            step();
            k++;
        end
        ld_valid = 1'b0;
        chk("im_we_pulses", nb, IM);
        chk("run_entry_cpu_en", cpu_en, 1);
        chk("run_entry_pc", pc_out, 0);
        chk("ld_ready_off", ld_ready, 0);
    endtask

    task automatic run_a(output int n);
        n = 0;
        while (cpu_en && n < 200) begin
            chk("run_pc", pc_out, 4 * n);
            step();
            n++;
        end
    endtask

    task automatic dump_a(input bit stall);
        int  w   = 0;
        int  sc  = 0;
        int  cyc = 0;
        bit  rdy;
        while (w < NR && cyc < 400) begin
            rdy = !(stall && (w == 0 || w == 5 || w == NR - 1) && sc < 3);
            dump_ready = rdy;
            chk("dump_valid", dump_valid, 1);
            chk("dump_data", dump_data, rf_val(5'(w)));
            chk("dump_last", dump_last, w == NR - 1);
            step();
            cyc++;
            if (rdy) begin
                w++;
                sc = 0;
            end else begin
                sc++;
            end
        end
        dump_ready = 1'b0;
        chk("dump_words", w, NR);
        chk("dump_cycles", cyc, stall ? NR + 9 : NR);
        chk("done_after_last", done, 1);
        chk("dump_valid_off", dump_valid, 0);
        chk("busy_off", busy, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start_b = 1'b0; ld_valid = 1'b0;
        ld_data = 8'h00; dump_ready = 1'b0; pc_mode = 0;
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_flags", {timeout, misalign}, 0);
        rst = 1'b0;
        step();

        // Abandon a load part way through
        pulse_start(1'b0);
        chk("mid_ld_ready", ld_ready, 1);
        chk("mid_busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i);
            #1;
            chk("mid_im_addr", im_addr, i);
            step();
        end
        rst = 1'b1;
        step();
        chk("mid_rst_ld_ready", ld_ready, 0);
        chk("mid_rst_im_we", im_we, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        ld_valid = 1'b0;
        step();

        // Straight-line program with dump backpressure
        pc_mode = 0;
        load_a();
        run_a(n);
        chk("straight_run_cycles", n, IM / 4);
        chk("straight_pc_held", pc_out, IM - 4);
        chk("straight_flags", {timeout, misalign}, 0);
        dump_a(1'b1);

        // Misaligned branch target at pc 4
        pc_mode = 2;
        load_a();
        run_a(n);
        chk("mis_run_cycles", n, 2);
        chk("mis_pc_held", pc_out, 4);
        chk("mis_flag", misalign, 1);
        chk("mis_timeout", timeout, 0);
        dump_a(1'b0);
        chk("mis_flag_held", misalign, 1);

        // Watchdog on the short-limit instance
        pc_mode = 1;
        pulse_start(1'b1);
        chk("wd_ld_ready", ld_ready_b, 1);
        for (int i = 0; i < IM; i++) begin
            ld_valid = 1'b1;
            step();
        end
        ld_valid = 1'b0;
        chk("wd_run_entry", cpu_en_b, 1);
        n = 0;
        while (cpu_en_b && n < 100) begin
            step();
            n++;
        end
        chk("wd_run_cycles", n, 16);
        chk("wd_timeout", timeout_b, 1);
        chk("wd_misalign", misalign_b, 0);
        chk("wd_pc", pc_out_b, 8);
        chk("wd_dump_valid", dump_valid_b, 1);
        dump_ready = 1'b1;
        for (int w = 0; w < NR; w++) begin
            chk("wd_dump_data", dump_data_b, rf_val(5'(w)));
            step();
        end
        dump_ready = 1'b0;
        chk("wd_done", done_b, 1);
        chk("wd_timeout_held", timeout_b, 1);

        // Restart from DONE clears sticky flags
        pulse_start(1'b0);
        chk("restart_misalign", misalign, 0);
        chk("restart_ld_ready", ld_ready, 1);
        chk("restart_done", done, 0);
        chk("restart_im_addr", im_addr, 0);
        pulse_start(1'b1);
        chk("restart_timeout", timeout_b, 0);
        chk("restart_busy_b", busy_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
